// File: rtl/memory_responder.sv
// Single-port word memory behind a ready/valid request interface (IDLE/WAIT/ACCESS/RESPOND FSM).
// Optional macro MEM_WAIT_STATES_EN adds WAIT_CYCLES wait states before each access.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        access_fault
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef MEM_WAIT_STATES_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] wait_cnt_r;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;
  localparam int unsigned UNUSED_WAIT_CYCLES = WAIT_CYCLES;
`endif

  state_t            state_r;
  state_t            next_state_s;
  logic              accept_s;
  logic              ready_nxt_s;
  logic              valid_nxt_s;
  logic              fault_nxt_s;
  logic              cmd_r;
  logic              oor_r;
  logic [IDX_W-1:0]  idx_r;
  logic [31:0]       wdata_r;
  logic [3:0]        strb_r;
  logic [31:0]       read_data_r;
  logic              ready_r;
  logic              valid_r;
  logic              fault_r;
  logic [31:0]       mem_r [0:DEPTH_WORDS-1];
  logic              unused_addr_s;

  assign unused_addr_s = ^address[1:0];
  assign accept_s      = (state_r == ST_IDLE) && memory_enable;

  // State register; synchronous reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
`ifdef MEM_WAIT_STATES_EN
          if (WAIT_CYCLES > 0) begin
            next_state_s = ST_WAIT;
          end else begin
            next_state_s = ST_ACCESS;
          end
`else
          next_state_s = ST_ACCESS;
`endif
        end else begin
          next_state_s = ST_IDLE;
        end
      end
`ifdef MEM_WAIT_STATES_EN
      ST_WAIT: begin
        if (wait_cnt_r <= CNT_W'(1)) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
`endif
      ST_ACCESS:  next_state_s = ST_RESPOND;
      ST_RESPOND: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the output flops line up with the state flop
  always_comb begin
    ready_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    fault_nxt_s = 1'b0;
    case (next_state_s)
      ST_IDLE:    ready_nxt_s = 1'b1;
      ST_RESPOND: begin
        valid_nxt_s = 1'b1;
        fault_nxt_s = oor_r;
      end
      default: begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        fault_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

`ifdef MEM_WAIT_STATES_EN
  // Wait-state down-counter, loaded at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (accept_s) begin
      wait_cnt_r <= CNT_W'(WAIT_CYCLES);
    end else if ((state_r == ST_WAIT) && (wait_cnt_r != '0)) begin
      wait_cnt_r <= wait_cnt_r - CNT_W'(1);
    end
  end
`endif

  // Request latch; the range check is resolved here so later input changes cannot matter
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r   <= 1'b0;
      oor_r   <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'd0;
      strb_r  <= 4'd0;
    end else if (accept_s) begin
      cmd_r   <= memory_command;
      oor_r   <= ({2'b00, address[31:2]} >= 32'(DEPTH_WORDS));
      idx_r   <= address[IDX_W+1:2];
      wdata_r <= write_data;
      strb_r  <= write_strobe;
    end
  end

  // Read capture; faulted requests return zero, writes leave the last read value in place
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_r <= 32'd0;
    end else if (state_r == ST_ACCESS) begin
      if (oor_r) begin
        read_data_r <= 32'd0;
      end else if (!cmd_r) begin
        read_data_r <= mem_r[idx_r];
      end
    end
  end

  // Array write with byte enables; contents survive reset, a reset in ACCESS drops the write
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_ACCESS) && cmd_r && !oor_r) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_r[i]) begin
          mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign memory_ready = ready_r;
  assign memory_valid = valid_r;
  assign access_fault = fault_r;
  assign read_data    = read_data_r;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: directed cases plus randomized traffic against
// an associative-array memory model; a separate monitor checks every completion.
module tb_memory_responder;

  localparam int DEPTH = 4096;
  localparam int WAITC = 3;
`ifdef MEM_WAIT_STATES_EN
  localparam int LAT = 2 + WAITC;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memory_enable = 1'b0;
  logic        memory_command = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [3:0]  write_strobe = 4'd0;
  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] read_data;
  logic        access_fault;

  memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk            (clk),
    .reset          (reset),
    .memory_enable  (memory_enable),
    .memory_command (memory_command),
    .address        (address),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .memory_ready   (memory_ready),
    .memory_valid   (memory_valid),
    .read_data      (read_data),
    .access_fault   (access_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          cmd;
    bit          fault;
    bit          known;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_checks = 0;
  int          n_err = 0;
  int          last_acc = -100;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: word = addr/4, fault beyond DEPTH, byte-merge on write
  function automatic exp_t model_apply(bit cmd, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    exp_t        e;
    int unsigned w;
    logic [31:0] cur;
    w       = addr >> 2;
    e.cmd   = cmd;
    e.fault = (w >= DEPTH);
    e.known = 1'b1;
    e.data  = 32'd0;
    e.due   = 0;
    if (!e.fault) begin
      if (cmd) begin
        cur = model.exists(int'(w)) ? model[int'(w)] : 32'd0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
        if (model.exists(int'(w)) || strb == 4'hF) model[int'(w)] = cur;
      end else if (model.exists(int'(w))) begin
        e.data = model[int'(w)];
      end else begin
        e.known = 1'b0;
      end
    end
    return e;
  endfunction

  // Wait for ready (bounded) while scrambling inputs, then present one request
  task automatic issue(bit cmd, logic [31:0] addr, logic [31:0] data, logic [3:0] strb, bit push, bit hold);
    bit   done = 1'b0;
    exp_t e;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      check32("ready", {31'd0, memory_ready}, {31'd0, (cyc > last_acc + LAT)});
      if (memory_ready) begin
        if (hold && t > 0) check32("b2b_interval", 32'(cyc - last_acc), 32'(LAT + 1));
        memory_enable  = 1'b1;
        memory_command = cmd;
        address        = addr;
        write_data     = data;
        write_strobe   = strb;
        if (push) begin
          e     = model_apply(cmd, addr, data, strb);
          e.due = cyc + LAT;
          sb.push_back(e);
        end
        last_acc = cyc;
        done     = 1'b1;
      end else begin
        memory_enable  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        memory_command = 1'($urandom);
        address        = $urandom;
        write_data     = $urandom;
        write_strobe   = 4'($urandom);
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL issue_timeout: got no ready expected ready within 40 cycles");
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      check32("ready_idle", {31'd0, memory_ready}, {31'd0, (cyc > last_acc + LAT)});
      memory_enable = 1'b0;
    end
  endtask

  task automatic check_reset_state();
    check32("rst_ready", {31'd0, memory_ready}, 32'd1);
    check32("rst_valid", {31'd0, memory_valid}, 32'd0);
    check32("rst_fault", {31'd0, access_fault}, 32'd0);
    check32("rst_read_data", read_data, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h0000_4000;
    return 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && memory_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid: got valid expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check32("valid_cycle", 32'(cyc), 32'(e.due));
        check32("ready_in_valid", {31'd0, memory_ready}, 32'd0);
        check32("access_fault", {31'd0, access_fault}, {31'd0, e.fault});
        if (e.fault || (!e.cmd && e.known)) check32("read_data", read_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with enable held high must not accept anything
    memory_enable = 1'b1;
    address       = 32'h10;
    repeat (3) @(negedge clk);
    reset         = 1'b0;
    memory_enable = 1'b0;
    check_reset_state();

    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w << 2), $urandom, 4'hF, 1'b1, 1'b0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0);
    issue(1'b1, 32'h20, 32'h0000AA00, 4'h2, 1'b1, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h4000, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0);
    issue(1'b0, 32'h4000, 32'h0, 4'h0, 1'b1, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Reset one cycle after accepting a write: the write must vanish
    issue(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    idle(LAT + 2);
    issue(1'b1, 32'h8, 32'h00000055, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    memory_enable = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    check_reset_state();
    last_acc = -100;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), rand_addr(), $urandom, 4'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    // Back-to-back reads with enable never dropped
    for (int i = 0; i < 20; i++) issue(1'b0, rand_addr(), 32'h0, 4'h0, 1'b1, 1'b1);

    idle(LAT + 3);
    check32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
